// File: rtl/lsu_result_fifo_if.sv
// Result-packet format and the push/pop handshake bundle between the LSU
// issue queue, the result FIFO and the CDB arbiter.
typedef struct packed {
    logic [5:0]  rob_id;
    logic [31:0] value;
    logic        exception;
} cdb_info_t;

interface lsu_result_fifo_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PTR_LEN = $clog2(DEPTH)
);
    logic             push_valid_i;
    logic             push_ready_o;
    cdb_info_t        push_data_i;
    logic             pop_valid_o;
    logic             pop_ready_i;
    cdb_info_t        pop_data_o;
    logic [PTR_LEN:0] count_o;
    logic             almost_full_o;

    modport master (
        output push_valid_i, push_data_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, pop_data_o, count_o, almost_full_o
    );

    modport slave (
        input  push_valid_i, push_data_i, pop_ready_i,
        output push_ready_o, pop_valid_o, pop_data_o, count_o, almost_full_o
    );
endinterface

// File: rtl/lsu_result_fifo.sv
// First-word-fall-through circular FIFO buffering LSU results ahead of the
// CDB arbiter; registered occupancy, single-cycle flush.
module lsu_result_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PTR_LEN = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    lsu_result_fifo_if.slave  io
);
    localparam logic [PTR_LEN:0]   FULL_CNT = (PTR_LEN + 1)'(DEPTH);
    localparam logic [PTR_LEN:0]   AF_CNT   = (PTR_LEN + 1)'(DEPTH - 1);
    localparam logic [PTR_LEN:0]   CNT_ONE  = (PTR_LEN + 1)'(1);
    localparam logic [PTR_LEN-1:0] PTR_ONE  = PTR_LEN'(1);

    cdb_info_t          mem [DEPTH];
    logic [PTR_LEN-1:0] head_q;
    logic [PTR_LEN-1:0] tail_q;
    logic [PTR_LEN:0]   cnt_q;
    logic [PTR_LEN:0]   cnt_next;
    logic               af_q;
    logic               push;
    logic               pop;

    // Full FIFO still accepts when the head leaves in the same cycle.
    assign io.push_ready_o  = (cnt_q != FULL_CNT) | io.pop_ready_i;
    assign io.pop_valid_o   = (cnt_q != '0);
    assign io.pop_data_o    = mem[head_q];
    assign io.count_o       = cnt_q;
    assign io.almost_full_o = af_q;

    assign push = io.push_valid_i & io.push_ready_o;
    assign pop  = io.pop_valid_o & io.pop_ready_i;

    always_comb begin
        cnt_next = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_next = cnt_q + CNT_ONE;
            2'b01:   cnt_next = cnt_q - CNT_ONE;
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            af_q   <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + PTR_ONE;
            if (pop)  head_q <= head_q + PTR_ONE;
            cnt_q <= cnt_next;
            af_q  <= (cnt_next >= AF_CNT);
        end
    end

    // Storage is never cleared; a write coinciding with flush/reset is dropped.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[tail_q] <= io.push_data_i;
    end
endmodule

// File: tb/tb_lsu_result_fifo.sv
// Self-checking bench for lsu_result_fifo: directed vector table, hand-written
// corner sequences and randomized traffic against a queue reference model.
module tb_lsu_result_fifo;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    lsu_result_fifo_if #(.DEPTH(DEPTH)) bus ();

    lsu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    cdb_info_t q[$];
    bit        model_on = 1'b0;
    bit        cur_rst, cur_flush, will_push, will_pop;
    cdb_info_t cur_pkt;

    typedef struct {
        logic       r, f, pv;
        logic [5:0] rid;
        logic       pr;
        logic       chk;
        logic [2:0] cnt;
        logic       pvld, prdy, af;
        logic [5:0] head;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic cdb_info_t mk(input logic [5:0] rid);
        cdb_info_t p;
        p.rob_id    = rid;
        p.value     = $urandom;
        p.exception = 1'($urandom);
        return p;
    endfunction

    // Drive one cycle of inputs, then compare settled outputs with the model.
    task automatic cyc(input logic r, input logic f, input logic pv,
                       input logic [5:0] rid, input logic pr);
        cdb_info_t pkt;
        int        sz;
        bit        rdy;
        pkt = mk(rid);
        rst              = r;
        flush            = f;
        bus.push_valid_i = pv;
        bus.push_data_i  = pkt;
        bus.pop_ready_i  = pr;
        #2;
        sz  = q.size();
        rdy = (sz < DEPTH) || pr;
        if (model_on) begin
            chk("model_count",      64'(bus.count_o),       64'(sz));
            chk("model_pop_valid",  64'(bus.pop_valid_o),   64'(sz > 0));
            chk("model_push_ready", 64'(bus.push_ready_o),  64'(rdy));
            chk("model_almost_full", 64'(bus.almost_full_o), 64'(sz >= DEPTH - 1));
            if (sz > 0) chk("model_pop_data", 64'(bus.pop_data_o), 64'(q[0]));
        end
        cur_rst   = r;
        cur_flush = f;
        cur_pkt   = pkt;
        will_push = pv && rdy;
        will_pop  = pr && (sz > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (cur_rst || cur_flush) begin
            q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            if (will_pop)  void'(q.pop_front());
            if (will_push) q.push_back(cur_pkt);
        end
    endtask

    initial begin
        int pv_pct, pr_pct;
        int drain;

        // r f pv rid pr | chk cnt pvld prdy af head
        tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 0,  1, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 2, 0,  1, 1, 1, 1, 0, 1};
        tbl[4]  = '{0, 0, 1, 3, 0,  1, 2, 1, 1, 0, 1};
        tbl[5]  = '{0, 0, 1, 4, 0,  1, 3, 1, 1, 1, 1};
        tbl[6]  = '{0, 0, 1, 5, 0,  1, 4, 1, 0, 1, 1};
        tbl[7]  = '{0, 0, 1, 5, 0,  1, 4, 1, 0, 1, 1};
        tbl[8]  = '{0, 0, 1, 5, 1,  1, 4, 1, 1, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 1,  1, 4, 1, 1, 1, 2};
        tbl[10] = '{0, 0, 0, 0, 1,  1, 3, 1, 1, 1, 3};
        tbl[11] = '{0, 0, 0, 0, 1,  1, 2, 1, 1, 0, 4};
        tbl[12] = '{0, 0, 0, 0, 1,  1, 1, 1, 1, 0, 5};
        tbl[13] = '{0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].f, tbl[i].pv, tbl[i].rid, tbl[i].pr);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_count", i),       64'(bus.count_o),       64'(tbl[i].cnt));
                chk($sformatf("tbl%0d_pop_valid", i),   64'(bus.pop_valid_o),   64'(tbl[i].pvld));
                chk($sformatf("tbl%0d_push_ready", i),  64'(bus.push_ready_o),  64'(tbl[i].prdy));
                chk($sformatf("tbl%0d_almost_full", i), 64'(bus.almost_full_o), 64'(tbl[i].af));
                if (tbl[i].pvld)
                    chk($sformatf("tbl%0d_head", i), 64'(bus.pop_data_o.rob_id), 64'(tbl[i].head));
            end
            tick();
        end

        // Full FIFO accepts a push when the head pops the same cycle.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 6'(10 + i), 0);
            tick();
        end
        cyc(0, 0, 1, 9, 1);
        chk("full_pop_push_ready", 64'(bus.push_ready_o), 64'(1));
        chk("full_pop_count",      64'(bus.count_o),      64'(4));
        tick();
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 0, 0, 0, 1);
            chk($sformatf("full_pop_count_%0d", k), 64'(bus.count_o), 64'(5 - k));
            chk($sformatf("full_pop_head_%0d", k), 64'(bus.pop_data_o.rob_id),
                64'((k == 4) ? 9 : 10 + k));
            tick();
        end

        // Back-to-back push+pop pairs: steady count of 1, pointers wrap.
        cyc(0, 0, 1, 20, 1);
        chk("wrap_start_count", 64'(bus.count_o), 64'(0));
        tick();
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 1, 6'(20 + i), 1);
            chk($sformatf("wrap_count_%0d", i), 64'(bus.count_o), 64'(1));
            chk($sformatf("wrap_head_%0d", i), 64'(bus.pop_data_o.rob_id), 64'(20 + i - 1));
            tick();
        end
        cyc(0, 0, 0, 0, 1);
        chk("wrap_last_head", 64'(bus.pop_data_o.rob_id), 64'(30));
        tick();

        // Flush with push and pop both active discards everything.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 6'(40 + i), 0);
            tick();
        end
        cyc(0, 1, 1, 43, 1);
        chk("flush_pre_count", 64'(bus.count_o), 64'(3));
        tick();
        cyc(0, 0, 0, 0, 0);
        chk("flush_count",     64'(bus.count_o),     64'(0));
        chk("flush_pop_valid", 64'(bus.pop_valid_o), 64'(0));
        tick();
        cyc(0, 0, 1, 7, 0);
        tick();
        cyc(0, 0, 0, 0, 1);
        chk("flush_next_valid", 64'(bus.pop_valid_o),        64'(1));
        chk("flush_next_head",  64'(bus.pop_data_o.rob_id),  64'(7));
        chk("flush_next_count", 64'(bus.count_o),            64'(1));
        tick();

        // Randomized traffic with shifting push/pop pressure.
        pv_pct = 50;
        pr_pct = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                pv_pct = $urandom_range(10, 100);
                pr_pct = $urandom_range(10, 100);
            end
            cyc(1'($urandom_range(0, 999) == 0),
                1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 99) < pv_pct),
                6'($urandom),
                1'($urandom_range(0, 99) < pr_pct));
            tick();
        end

        drain = 0;
        while (q.size() > 0 && drain < 2 * DEPTH) begin
            cyc(0, 0, 0, 0, 1);
            tick();
            drain++;
        end
        cyc(0, 0, 0, 0, 0);
        chk("drain_empty_count", 64'(bus.count_o),     64'(0));
        chk("drain_empty_valid", 64'(bus.pop_valid_o), 64'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_result_fifo.md
# lsu_result_fifo

Buffers load/store results returned by the LSU issue queue before they reach the CDB arbiter. It decouples DCache response timing from CDB grant timing. It sits between the issue queue's result port and the CDB arbiter, and is a first-word-fall-through circular FIFO with a registered occupancy count. A pipeline flush empties it in one cycle.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `PTR_LEN`, `$clog2(DEPTH)`: pointer width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush; same effect as `rst`.
- `push_valid_i`  in  1  upstream result valid (driven by the issue queue's `entry_valid_o`).
- `push_ready_o`  out  1  FIFO can accept (drives the issue queue's `fifo_ready`).
- `push_data_i`  in  `cdb_info_t`  result packet.
- `pop_valid_o`  out  1  head entry valid toward the CDB arbiter.
- `pop_ready_i`  in  1  CDB arbiter grant.
- `pop_data_o`  out  `cdb_info_t`  head packet.
- `count_o`  out  `PTR_LEN+1`  registered occupancy, 0..DEPTH.
- `almost_full_o`  out  1  registered; `count_o >= DEPTH-1`.

## Operation
- State:
  - `head_q` and `tail_q`: `PTR_LEN` bits each.
  - `cnt_q`: `PTR_LEN+1` bits.
  - Storage: `mem[DEPTH]` of `cdb_info_t`.
- Push fire: `push = push_valid_i & push_ready_o`.
  - Write `mem[tail_q] <= push_data_i`.
  - `tail_q <= tail_q + 1`; the natural wrap from DEPTH-1 to 0 is required.
- Pop fire: `pop = pop_valid_o & pop_ready_i`.
  - `head_q <= head_q + 1`, with the same wrap rule.
- Count update: `cnt_q <= cnt_q + push - pop`.
  - Width is `PTR_LEN+1`, so DEPTH is representable; no overflow is possible.
- Outputs:
  - `pop_valid_o = (cnt_q != 0)`.
  - `pop_data_o = mem[head_q]` (combinational read).
  - `push_ready_o = (cnt_q != DEPTH) | pop_ready_i`. Push while full is allowed when the head is popped the same cycle.
- Empty: no bypass; a packet pushed into an empty FIFO appears on `pop_data_o` the next cycle.
- Full: with `pop_ready_i=0`, `push_ready_o=0`. Upstream holds its data; none is dropped or overwritten.
- Simultaneous push and pop at any count:
  - `cnt_q` is unchanged.
  - Both pointers advance.
  - Order is preserved.
- Flush/reset:
  - `head_q`, `tail_q` and `cnt_q` clear to 0.
  - A push or pop in the same cycle is discarded.
  - `mem` is not cleared.
- Entries are never reordered or modified; `pop_data_o` equals the pushed packet bit-for-bit.

## Timing
- Push-to-pop latency: 1 cycle minimum.
- Throughput: 1 push and 1 pop per cycle sustained at any occupancy.
- Outputs are combinational from state; `push_ready_o` is combinational from `pop_ready_i` only.
- Reset values:

| Output | Reset value |
|---|---|
| `pop_valid_o` | 0 |
| `push_ready_o` | 1 |
| `count_o` | 0 |
| `almost_full_o` | 0 |
| `pop_data_o` | don't-care (qualified by `pop_valid_o`) |

- `count_o` and `almost_full_o` reflect the state after the previous edge.
- Valid/ready rule: a fire occurs only in a cycle where valid and ready are both high. The FIFO never drops `pop_valid_o` without a pop or flush.
- Reset or flush asserted mid-stream: the next cycle shows empty state regardless of the in-flight handshake.

## Test plan
1. **Reset:** hold `rst` 2 cycles, then release.
   - Expect `count_o=0`, `pop_valid_o=0`, `push_ready_o=1` on the first cycle after release.
2. **Fill then drain** (DEPTH=4, `pop_ready_i=0`): push rob_id 1,2,3,4.
   - After 4 pushes: `count_o=4`, `push_ready_o=0`, `almost_full_o=1`.
   - A 5th push (rob_id 5) held by the source stays unaccepted.
   - Then raise `pop_ready_i`: pops yield 1,2,3,4,5 in order.
3. **Wrap-around:** 10 back-to-back push+pop pairs with `pop_ready_i=1`.
   - Every packet appears exactly 1 cycle after its push.
   - `count_o` stays at 1 throughout.
   - Pointers wrap past 3 with order intact.
4. **Full plus same-cycle pop:** at `count_o=4`, assert `pop_ready_i=1` and push rob_id 9.
   - Push is accepted; `count_o` stays 4.
   - rob_id 9 exits 4 pops later.
5. **Flush mid-stream:** `count_o=3`, with push and pop both asserted, then pulse `flush`.
   - Next cycle: `count_o=0`, `pop_valid_o=0`.
   - The next pushed packet (rob_id 7) is the first popped.
6. **Random stress:** 10k cycles of random `push_valid_i`/`pop_ready_i` against a scoreboard queue model.
   - No loss, duplication or reordering.
   - `count_o` always matches the model.
